// File: rtl/alu_exec_if.sv
// Request/response bundle between the issue logic and alu_exec_unit.
// The requester drives the master side and the execute unit uses the slave side.
interface alu_exec_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   InValid;
  logic                   InReady;
  logic [3:0]             ALUCtrl;
  logic [DATA_WIDTH-1:0]  BusA;
  logic [DATA_WIDTH-1:0]  BusB;
  logic [SHAMT_WIDTH-1:0] Shamt;
  logic                   OutValid;
  logic                   OutReady;
  logic [DATA_WIDTH-1:0]  BusW;
  logic                   Zero;
  logic                   Overflow;
  logic                   Illegal;

  modport master (
    output InValid, ALUCtrl, BusA, BusB, Shamt, OutReady,
    input  InReady, OutValid, BusW, Zero, Overflow, Illegal
  );

  modport slave (
    input  InValid, ALUCtrl, BusA, BusB, Shamt, OutReady,
    output InReady, OutValid, BusW, Zero, Overflow, Illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execute stage with registered result and Zero/Overflow/Illegal flags.
// Define BARREL_SHIFT_EN for one-cycle shifts; otherwise shifts run serially, one bit per cycle.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic       CLK,
  input logic       Reset_L,
  alu_exec_if.slave bus
);
  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011, OP_SRL  = 4'b0100, OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111, OP_ADDU = 4'b1000, OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010, OP_SLTU = 4'b1011, OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam int         MSB     = DATA_WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] w;
    logic                  ovf;
    logic                  ill;
  } res_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] busw_q;
  logic                  zero_q;
  logic                  ovf_q;
  logic                  ill_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sh_val;
  res_t                  res;

  function automatic logic [DATA_WIDTH-1:0] shift_by(input logic [DATA_WIDTH-1:0]  v,
                                                     input logic [3:0]             c,
                                                     input logic [SHAMT_WIDTH-1:0] amt);
    logic signed [DATA_WIDTH-1:0] sv;
    sv = v;
    case (c)
      OP_SLL:  return v << amt;
      OP_SRL:  return v >> amt;
      default: return sv >>> amt;
    endcase
  endfunction

  function automatic res_t compute(input logic [3:0]            c,
                                   input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic [DATA_WIDTH-1:0] shv);
    logic signed [DATA_WIDTH-1:0] sa;
    logic signed [DATA_WIDTH-1:0] sb;
    logic [DATA_WIDTH-1:0]        sum;
    logic [DATA_WIDTH-1:0]        diff;
    res_t                         r;
    sa   = a;
    sb   = b;
    sum  = a + b;
    diff = a - b;
    r    = '0;
    case (c)
      OP_AND:  r.w = a & b;
      OP_OR:   r.w = a | b;
      OP_XOR:  r.w = a ^ b;
      OP_NOR:  r.w = ~(a | b);
      OP_ADD:  begin r.w = sum;  r.ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);  end
      OP_SUB:  begin r.w = diff; r.ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]); end
      OP_ADDU: r.w = sum;
      OP_SUBU: r.w = diff;
      OP_SLT:  r.w = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: r.w = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: r.w = shv;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  assign bus.InReady = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.OutReady);
  assign accept      = bus.InValid && bus.InReady;

`ifdef BARREL_SHIFT_EN
  assign sh_val = shift_by(bus.BusB, bus.ALUCtrl, bus.Shamt);
`else
  // Serial build: the shift source is loaded into busw_q and shifted in place.
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic [3:0]             sop_q;
  logic [DATA_WIDTH-1:0]  step;

  function automatic logic is_shift(input logic [3:0] c);
    return (c == OP_SLL) || (c == OP_SRL) || (c == OP_SRA);
  endfunction

  assign sh_val = bus.BusB;
  assign step   = shift_by(busw_q, sop_q, SHAMT_WIDTH'(1));
`endif

  assign res = compute(bus.ALUCtrl, bus.BusA, bus.BusB, sh_val);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= S_IDLE;
      busw_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifndef BARREL_SHIFT_EN
      cnt_q   <= '0;
      sop_q   <= '0;
`endif
    end else if (accept) begin
`ifndef BARREL_SHIFT_EN
      if (is_shift(bus.ALUCtrl) && (bus.Shamt != '0)) begin
        state_q <= S_SHIFT;
        busw_q  <= bus.BusB;
        cnt_q   <= bus.Shamt;
        sop_q   <= bus.ALUCtrl;
        zero_q  <= 1'b0;
        ovf_q   <= 1'b0;
        ill_q   <= 1'b0;
      end else
`endif
      begin
        state_q <= S_DONE;
        busw_q  <= res.w;
        zero_q  <= (res.w == '0);
        ovf_q   <= res.ovf;
        ill_q   <= res.ill;
      end
    end else if ((state_q == S_DONE) && bus.OutReady) begin
      state_q <= S_IDLE;
    end
`ifndef BARREL_SHIFT_EN
    else if (state_q == S_SHIFT) begin
      busw_q <= step;
      cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
      if (cnt_q == SHAMT_WIDTH'(1)) begin
        state_q <= S_DONE;
        zero_q  <= (step == '0);
      end
    end
`endif
  end

  assign bus.OutValid = (state_q == S_DONE);
  assign bus.BusW     = busw_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
  assign bus.Illegal  = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed ops with literal expectations plus a
// cycle-by-cycle reference model of result, flags, valid and ready.
module tb_alu_exec_unit;
  localparam int W  = 32;
  localparam int SW = 5;
`ifdef BARREL_SHIFT_EN
  localparam bit SERIAL = 1'b0;
`else
  localparam bit SERIAL = 1'b1;
`endif

  logic CLK = 1'b0;
  logic Reset_L;
  always #5 CLK = ~CLK;

  alu_exec_if #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) bus ();
  alu_exec_unit #(.DATA_WIDTH(W), .SHAMT_WIDTH(SW)) dut (.CLK(CLK), .Reset_L(Reset_L), .bus(bus));

  int nchk  = 0;
  int npass = 0;

  typedef struct {
    logic [31:0] w;
    logic        z;
    logic        o;
    logic        i;
    int          rdy;
  } exp_t;

  exp_t q[$];
  int   edges = 0;
  bit   m_ev, m_er, m_acc, m_pop;
  exp_t m_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: plain 64-bit arithmetic; rdy temporarily holds latency in edges.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.w = 32'h0; e.o = 1'b0; e.i = 1'b0;
    case (c)
      4'b0000: e.w = a & b;
      4'b0001: e.w = a | b;
      4'b1010: e.w = a ^ b;
      4'b1100: e.w = ~(a | b);
      4'b0010: begin r = sa + sb; e.w = r[31:0]; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0110: begin r = sa - sb; e.w = r[31:0]; e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b1000: e.w = a + b;
      4'b1001: e.w = a - b;
      4'b0111: e.w = (sa < sb) ? 32'd1 : 32'd0;
      4'b1011: e.w = (a < b) ? 32'd1 : 32'd0;
      4'b0011: e.w = b << sh;
      4'b0100: e.w = b >> sh;
      4'b1101: begin r = sb >>> sh; e.w = r[31:0]; end
      default: e.i = 1'b1;
    endcase
    e.z = (e.w == 32'h0);
    if (SERIAL && (c == 4'b0011 || c == 4'b0100 || c == 4'b1101) && sh != 5'd0) e.rdy = int'(sh) + 1;
    else e.rdy = 1;
    return e;
  endfunction

  // Model update on each edge (pre-edge inputs), then compare shortly after.
  always @(posedge CLK) begin
    if (!Reset_L) begin
      q.delete();
      edges++;
    end else begin
      m_ev  = (q.size() > 0) && (edges >= q[0].rdy);
      m_er  = (q.size() == 0) || (m_ev && bus.OutReady);
      m_pop = m_ev && bus.OutReady;
      m_acc = bus.InValid && m_er;
      edges++;
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        m_e     = model(bus.ALUCtrl, bus.BusA, bus.BusB, bus.Shamt);
        m_e.rdy = edges + m_e.rdy - 1;
        q.push_back(m_e);
      end
    end
    #2;
    if (!Reset_L) begin
      chk("m_rst_outvalid", bus.OutValid, 0);
    end else begin
      m_ev = (q.size() > 0) && (edges >= q[0].rdy);
      m_er = (q.size() == 0) || (m_ev && bus.OutReady);
      chk("m_outvalid", bus.OutValid, m_ev);
      chk("m_inready", bus.InReady, m_er);
      if (m_ev) begin
        chk("m_busw", bus.BusW, q[0].w);
        chk("m_flags", {bus.Zero, bus.Overflow, bus.Illegal}, {q[0].z, q[0].o, q[0].i});
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    int k;
    @(negedge CLK);
    bus.InValid = 1'b1; bus.ALUCtrl = c; bus.BusA = a; bus.BusB = b; bus.Shamt = sh;
    k = 0;
    while (!bus.InReady && k < 100) begin @(negedge CLK); k++; end
    if (k >= 100) chk("accept_timeout", 1, 0);
    @(posedge CLK);
    @(negedge CLK);
    bus.InValid = 1'b0; bus.ALUCtrl = 4'b1111; bus.BusA = 32'hDEADBEEF; bus.BusB = 32'h12345678; bus.Shamt = 5'd7;
  endtask

  task automatic wait_out(output int waited, output int nrl);
    waited = 0; nrl = 0;
    while (!bus.OutValid && waited < 100) begin
      if (!bus.InReady) nrl++;
      @(negedge CLK);
      waited++;
    end
    if (waited >= 100) chk("out_timeout", 1, 0);
  endtask

  task automatic run(input string name, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] ew, input logic [2:0] ezoi);
    int wt, nr;
    issue(c, a, b, sh);
    wait_out(wt, nr);
    chk({name, "_w"}, bus.BusW, ew);
    chk({name, "_zoi"}, {bus.Zero, bus.Overflow, bus.Illegal}, ezoi);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt, nr;
    Reset_L = 1'b0;
    bus.InValid = 1'b0; bus.OutReady = 1'b1; bus.ALUCtrl = 4'b0; bus.BusA = '0; bus.BusB = '0; bus.Shamt = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busw", bus.BusW, 0);
    chk("rst_outvalid", bus.OutValid, 0);
    chk("rst_flags", {bus.Zero, bus.Overflow, bus.Illegal}, 3'b000);
    Reset_L = 1'b1;
    #1 chk("rst_inready", bus.InReady, 1);

    run("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 3'b010);
    run("addu",     4'b1000, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 3'b000);
    run("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 32'h0, 3'b100);
    run("sub_ovf",  4'b0110, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 3'b010);
    run("subu",     4'b1001, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 3'b000);
    run("slt",      4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 3'b000);
    run("sltu",     4'b1011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 3'b100);
    run("nor",      4'b1100, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 3'b000);
    run("sll4",     4'b0011, 32'h0, 32'h1, 5'd4, 32'h10, 3'b000);
    run("srl0",     4'b0100, 32'h0, 32'h80000000, 5'd0, 32'h80000000, 3'b000);
    run("srl_out",  4'b0100, 32'h0, 32'h00000001, 5'd1, 32'h0, 3'b100);

    // Longest shift: latency and ready-low window
    issue(4'b1101, 32'h0, 32'h80000000, 5'd31);
    wait_out(wt, nr);
    chk("sra31_w", bus.BusW, 32'hFFFFFFFF);
    chk("sra31_wait", wt, SERIAL ? 31 : 0);
    chk("sra31_rdylow", nr, SERIAL ? 31 : 0);

    run("illegal", 4'b1110, 32'h1234, 32'h5678, 5'd0, 32'h0, 3'b101);
    run("and_clr", 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 3'b000);

    // Hold under back-pressure, then same-edge accept of the next op
    issue(4'b0001, 32'h0000F000, 32'h000000F0, 5'd0);
    wait_out(wt, nr);
    bus.OutReady = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("hold_w", bus.BusW, 32'h0000F0F0);
      chk("hold_v", bus.OutValid, 1);
    end
    bus.OutReady = 1'b1; bus.InValid = 1'b1;
    bus.ALUCtrl = 4'b1010; bus.BusA = 32'hFF00FF00; bus.BusB = 32'h0F0F0F0F; bus.Shamt = 5'd0;
    #1 chk("done_inready", bus.InReady, 1);
    @(negedge CLK);
    bus.InValid = 1'b0;
    chk("xor_w", bus.BusW, 32'hF00FF00F);
    chk("xor_v", bus.OutValid, 1);

    // Back-to-back one-cycle ops
    @(negedge CLK);
    bus.InValid = 1'b1; bus.ALUCtrl = 4'b0010; bus.BusA = 32'd1; bus.BusB = 32'd2;
    @(negedge CLK);
    chk("b2b_v1", bus.OutValid, 1);
    chk("b2b_w1", bus.BusW, 32'd3);
    bus.ALUCtrl = 4'b0001; bus.BusA = 32'hA; bus.BusB = 32'h5;
    @(negedge CLK);
    chk("b2b_v2", bus.OutValid, 1);
    chk("b2b_w2", bus.BusW, 32'hF);
    bus.ALUCtrl = 4'b1001; bus.BusA = 32'd10; bus.BusB = 32'd3;
    @(negedge CLK);
    bus.InValid = 1'b0;
    chk("b2b_v3", bus.OutValid, 1);
    chk("b2b_w3", bus.BusW, 32'd7);
    @(negedge CLK);
    chk("b2b_idle", bus.OutValid, 0);

    // Asynchronous reset while a result is pending
    bus.OutReady = 1'b0;
    issue(4'b0100, 32'h0, 32'hFFFF0000, 5'd20);
    @(negedge CLK);
    #2 Reset_L = 1'b0;
    #1;
    chk("arst_outvalid", bus.OutValid, 0);
    chk("arst_busw", bus.BusW, 0);
    chk("arst_zero", bus.Zero, 0);
    @(negedge CLK);
    Reset_L = 1'b1;
    bus.OutReady = 1'b1;
    #1 chk("arst_inready", bus.InReady, 1);

    run("post_rst", 4'b0010, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 3'b100);
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
